multicycle_control_unit: RTL

Multi-cycle control sequencer for the RV32I core. It replaces single-cycle opcode decoding with a state machine that steps each instruction through fetch, decode, execute, memory and write-back. Instruction and data memory are accessed through one request/ready handshake, with an optional watchdog on that handshake. It sits between the instruction register and the datapath, and drives the same datapath strobes (MemRead, MemWrite, ALUsrc, branch, RegWrite, ALUop) plus the sequencing strobes.

---
 rtl/multicycle_control_unit.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXECUTE/MEM/WB with a TRAP sink.
// Optional memory-handshake watchdog enabled by defining CTRL_MEM_WATCHDOG_EN.
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       ir_write,
    output logic       pc_write,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       ALUsrc,
    output logic       branch,
    output logic       RegWrite,
    output logic [1:0] ALUop,
    output logic [2:0] state,
    output logic       illegal,
    output logic       timeout
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_TRAP    = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CL_R, CL_IALU, CL_LOAD, CL_JALR, CL_STORE, CL_BR, CL_LUI, CL_AUIPC, CL_JAL, CL_ILL
    } cls_t;

    if (MEM_TIMEOUT < 1) begin : g_bad_timeout
        $error("MEM_TIMEOUT must be at least 1");
    end

    state_t state_q, state_d;
    cls_t   cls_q, cls_dec;
    logic   illegal_q, timeout_q;
    logic   wd_expire;

    always_comb begin
        case (opcode)
            7'b0110011: cls_dec = CL_R;
            7'b0010011: cls_dec = CL_IALU;
            7'b0000011: cls_dec = CL_LOAD;
            7'b1100111: cls_dec = CL_JALR;
            7'b0100011: cls_dec = CL_STORE;
            7'b1100011: cls_dec = CL_BR;
            7'b0110111: cls_dec = CL_LUI;
            7'b0010111: cls_dec = CL_AUIPC;
            7'b1101111: cls_dec = CL_JAL;
            default:    cls_dec = CL_ILL;
        endcase
    end

`ifdef CTRL_MEM_WATCHDOG_EN
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    logic [CW-1:0] wd_cnt_q;
    logic          wd_wait;

    assign wd_wait   = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
    // The wait cycle that would bring the count to MEM_TIMEOUT is the last one allowed.
    assign wd_expire = wd_wait && (wd_cnt_q == CW'(MEM_TIMEOUT - 1));
`else
    assign wd_expire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready)      state_d = S_DECODE;
                else if (wd_expire) state_d = S_TRAP;
            end
            S_DECODE:  state_d = (cls_dec == CL_ILL) ? S_TRAP : S_EXECUTE;
            S_EXECUTE: begin
                if (cls_q == CL_BR)                              state_d = S_FETCH;
                else if (cls_q == CL_LOAD || cls_q == CL_STORE)  state_d = S_MEM;
                else                                             state_d = S_WB;
            end
            S_MEM: begin
                if (mem_ready)      state_d = (cls_q == CL_LOAD) ? S_WB : S_FETCH;
                else if (wd_expire) state_d = S_TRAP;
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            cls_q     <= CL_R;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
`ifdef CTRL_MEM_WATCHDOG_EN
            wd_cnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            if (state_q == S_DECODE) cls_q <= cls_dec;
            illegal_q <= (state_q == S_DECODE) && (cls_dec == CL_ILL);
            timeout_q <= wd_expire;
`ifdef CTRL_MEM_WATCHDOG_EN
            if (state_d != state_q) wd_cnt_q <= '0;
            else if (wd_wait)       wd_cnt_q <= wd_cnt_q + CW'(1);
`endif
        end
    end

    // Strobes are decoded from the registered state; rst masks everything but the fetch request.
    always_comb begin
        mem_req  = 1'b0;
        ir_write = 1'b0;
        pc_write = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        ALUsrc   = 1'b0;
        branch   = 1'b0;
        RegWrite = 1'b0;
        ALUop    = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_req  = 1'b1;
                MemRead  = 1'b1;
                ir_write = mem_ready && !rst;
            end
            S_EXECUTE: if (!rst) begin
                ALUsrc = !(cls_q == CL_R || cls_q == CL_BR);
                case (cls_q)
                    CL_R, CL_IALU, CL_LOAD, CL_JALR: ALUop = 2'b10;
                    CL_BR:                           ALUop = 2'b01;
                    default:                         ALUop = 2'b00;
                endcase
                branch   = (cls_q == CL_BR);
                pc_write = (cls_q == CL_BR);
            end
            S_MEM: if (!rst) begin
                mem_req  = 1'b1;
                MemRead  = (cls_q == CL_LOAD);
                MemWrite = (cls_q == CL_STORE);
                pc_write = (cls_q == CL_STORE) && mem_ready;
            end
            S_WB: if (!rst) begin
                RegWrite = 1'b1;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign state   = state_q;
    assign illegal = illegal_q && !rst;
    assign timeout = timeout_q && !rst;

endmodule
